// File: rtl/uart_rx_deserializer_pkg.sv
// Shared types and constants for the UART receive path.
// PARITY_ODD selects the parity sense used when UART_RX_PARITY_EN is defined.
package uart_rx_deserializer_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // 0 = even parity, 1 = odd parity
    localparam logic PARITY_ODD = 1'b0;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// RST_VAL is the value both stages take under reset (line idle level).
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: start detect, mid-bit sampling, LSB-first framing, 1-cycle valid pulse.
// Optional parity bit and check enabled by defining UART_RX_PARITY_EN.
module uart_rx_deserializer
    import uart_rx_deserializer_pkg::*;
#(
    parameter int BAUD_DIV  = 434,
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 rx_busy
);

    localparam int              IDX_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_TGT = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_TGT  = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    rx_state_t              state;
    rx_state_t              state_nxt;
    logic                   rx_s;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       idx;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   tick;

    uart_rx_sync #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (rx_i),
        .q     (rx_s)
    );

    // START waits half a bit so every later tick lands mid-bit
    always_comb begin
        tick = 1'b0;
        if (state == RX_START)
            tick = (cnt == HALF_TGT);
        else
            tick = (cnt == BIT_TGT);
    end

    always_ff @(posedge clk) begin
        if (!n_rst)
            state <= RX_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE:
                if (!rx_s)
                    state_nxt = RX_START;
            RX_START:
                if (tick)
                    state_nxt = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:
                if (tick && (idx == LAST_IDX)) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = RX_PARITY;
`else
                    state_nxt = RX_STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
            RX_PARITY:
                if (tick)
                    state_nxt = RX_STOP;
`endif
            RX_STOP:
                if (tick)
                    state_nxt = rx_s ? RX_IDLE : RX_BREAK;
            RX_BREAK:
                if (rx_s)
                    state_nxt = RX_IDLE;
            default:
                state_nxt = RX_IDLE;
        endcase
    end

    assign rx_busy = (state != RX_IDLE);

`ifdef UART_RX_PARITY_EN
    logic parity_bit;
    logic parity_err_q;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            parity_bit   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= 1'b0;
            if (state == RX_PARITY && tick)
                parity_bit <= rx_s;
            if (state == RX_STOP && tick)
                parity_err_q <= (^shift_reg) ^ parity_bit ^ PARITY_ODD;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // Timer restarts on every state entry and on each bit tick; flags live for one cycle
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt       <= '0;
            idx       <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            if (state_nxt != state || tick || state == RX_IDLE || state == RX_BREAK)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);

            case (state)
                RX_START:
                    if (tick)
                        idx <= '0;
                RX_DATA:
                    if (tick) begin
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (idx != LAST_IDX)
                            idx <= idx + IDX_W'(1);
                    end
                RX_STOP:
                    if (tick) begin
                        rx_data   <= shift_reg;
                        rx_valid  <= 1'b1;
                        frame_err <= ~rx_s;
                    end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer (BAUD_DIV=16, DATA_BITS=8).
// Expected words come from a frame-level model; define UART_RX_PARITY_EN to test parity.
module tb_uart_rx_deserializer;
    import uart_rx_deserializer_pkg::*;

    localparam int BAUD_DIV  = 16;
    localparam int DATA_BITS = 8;
    localparam int CNT_W     = 16;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
        int         lat;
    } pulse_t;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       rx_i = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     start_cyc = 0;
    pulse_t got_q[$];
    pulse_t exp_q[$];

    uart_rx_deserializer #(
        .BAUD_DIV  (BAUD_DIV),
        .DATA_BITS (DATA_BITS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .rx_i       (rx_i),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Collect every pulse; the cycle after a pulse must be quiet with flags cleared
    initial begin
        logic prev_valid;
        pulse_t p;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (n_rst) begin
                if (prev_valid) begin
                    checks++;
                    if (rx_valid !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL pulse_after: valid/ferr/perr got %b%b%b expected 000",
                                 rx_valid, frame_err, parity_err);
                    end
                end
                if (rx_valid === 1'b1) begin
                    p.data = rx_data;
                    p.ferr = frame_err;
                    p.perr = parity_err;
                    p.lat  = cyc - start_cyc;
                    got_q.push_back(p);
                end
            end
            prev_valid = (n_rst === 1'b1) && (rx_valid === 1'b1);
        end
    end

    function automatic pulse_t model_frame(input logic [7:0] d, input logic stop, input logic par);
        pulse_t p;
        p.data = d;
        p.ferr = ~stop;
`ifdef UART_RX_PARITY_EN
        p.perr = (^d) ^ par ^ PARITY_ODD;
`else
        p.perr = 1'b0 & par;
`endif
        p.lat  = 0;
        return p;
    endfunction

    task automatic idle_bits(input int n);
        repeat (n * BAUD_DIV) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        @(negedge clk);
        rx_i = 1'b0;
        start_cyc = cyc;
        repeat (BAUD_DIV) @(negedge clk);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx_i = d[i];
            repeat (BAUD_DIV) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx_i = par;
        repeat (BAUD_DIV) @(negedge clk);
`endif
        rx_i = stop;
        repeat (BAUD_DIV) @(negedge clk);
        rx_i = 1'b1;
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            rx_i = ~rx_i;
        end
        checks += 5;
        if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", rx_data); end
        if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", rx_valid); end
        if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr: got %b expected 0", frame_err); end
        if (parity_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_perr: got %b expected 0", parity_err); end
        if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", rx_busy); end
        rx_i = 1'b1;
        @(negedge clk);
        n_rst = 1'b1;
        got_q.delete();
        idle_bits(2);
        checks += 2;
        if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %b expected 0", rx_busy); end
        if (got_q.size() != 0) begin errors++; $display("[TB] FAIL post_reset_pulses: got %0d expected 0", got_q.size()); end
    endtask

    task automatic test_basic_frame;
        got_q.delete();
        exp_q.delete();
        send_frame(8'hA5, 1'b1, (^8'hA5) ^ PARITY_ODD);
        exp_q.push_back(model_frame(8'hA5, 1'b1, (^8'hA5) ^ PARITY_ODD));
        repeat (2) @(negedge clk);
        checks += 2;
        if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy: got %b expected 0", rx_busy); end
        if (got_q.size() != 1) begin
            errors++;
            $display("[TB] FAIL basic_count: got %0d expected 1", got_q.size());
        end else begin
            checks += 4;
            if (got_q[0].data !== exp_q[0].data) begin errors++; $display("[TB] FAIL basic_data: got %h expected %h", got_q[0].data, exp_q[0].data); end
            if (got_q[0].ferr !== exp_q[0].ferr) begin errors++; $display("[TB] FAIL basic_ferr: got %b expected %b", got_q[0].ferr, exp_q[0].ferr); end
            if (got_q[0].perr !== exp_q[0].perr) begin errors++; $display("[TB] FAIL basic_perr: got %b expected %b", got_q[0].perr, exp_q[0].perr); end
`ifdef UART_RX_PARITY_EN
            if (got_q[0].lat < 171 || got_q[0].lat > 173) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 171..173", got_q[0].lat); end
`else
            if (got_q[0].lat < 154 || got_q[0].lat > 156) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 154..156", got_q[0].lat); end
`endif
        end
    endtask

    task automatic test_glitch;
        got_q.delete();
        exp_q.delete();
        @(negedge clk);
        rx_i = 1'b0;
        repeat (4) @(negedge clk);
        rx_i = 1'b1;
        idle_bits(2);
        checks += 2;
        if (got_q.size() != 0) begin errors++; $display("[TB] FAIL glitch_pulses: got %0d expected 0", got_q.size()); end
        if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy: got %b expected 0", rx_busy); end
        send_frame(8'h3C, 1'b1, (^8'h3C) ^ PARITY_ODD);
        exp_q.push_back(model_frame(8'h3C, 1'b1, (^8'h3C) ^ PARITY_ODD));
        repeat (2) @(negedge clk);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL glitch_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end else begin
            checks += 2;
            if (got_q[0].data !== exp_q[0].data) begin errors++; $display("[TB] FAIL glitch_data: got %h expected %h", got_q[0].data, exp_q[0].data); end
            if (got_q[0].ferr !== exp_q[0].ferr) begin errors++; $display("[TB] FAIL glitch_ferr: got %b expected %b", got_q[0].ferr, exp_q[0].ferr); end
        end
    endtask

    task automatic test_break;
        got_q.delete();
        exp_q.delete();
        send_frame(8'h55, 1'b0, (^8'h55) ^ PARITY_ODD);
        rx_i = 1'b0;
        exp_q.push_back(model_frame(8'h55, 1'b0, (^8'h55) ^ PARITY_ODD));
        idle_bits(40);
        checks += 2;
        if (rx_busy !== 1'b1) begin errors++; $display("[TB] FAIL break_busy: got %b expected 1", rx_busy); end
        if (got_q.size() != 1) begin
            errors++;
            $display("[TB] FAIL break_count: got %0d expected 1", got_q.size());
        end else begin
            checks += 2;
            if (got_q[0].data !== exp_q[0].data) begin errors++; $display("[TB] FAIL break_data: got %h expected %h", got_q[0].data, exp_q[0].data); end
            if (got_q[0].ferr !== exp_q[0].ferr) begin errors++; $display("[TB] FAIL break_ferr: got %b expected %b", got_q[0].ferr, exp_q[0].ferr); end
        end
        rx_i = 1'b1;
        idle_bits(2);
        checks++;
        if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL break_release_busy: got %b expected 0", rx_busy); end
        got_q.delete();
        exp_q.delete();
        send_frame(8'h0F, 1'b1, (^8'h0F) ^ PARITY_ODD);
        exp_q.push_back(model_frame(8'h0F, 1'b1, (^8'h0F) ^ PARITY_ODD));
        repeat (2) @(negedge clk);
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("[TB] FAIL after_break_count: got %0d expected 1", got_q.size());
        end else begin
            checks += 2;
            if (got_q[0].data !== exp_q[0].data) begin errors++; $display("[TB] FAIL after_break_data: got %h expected %h", got_q[0].data, exp_q[0].data); end
            if (got_q[0].ferr !== exp_q[0].ferr) begin errors++; $display("[TB] FAIL after_break_ferr: got %b expected %b", got_q[0].ferr, exp_q[0].ferr); end
        end
    endtask

    task automatic test_reset_midframe;
        got_q.delete();
        exp_q.delete();
        @(negedge clk);
        rx_i = 1'b0;
        repeat (BAUD_DIV) @(negedge clk);
        rx_i = 1'b1;
        repeat (5 * BAUD_DIV) @(negedge clk);
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        checks += 2;
        if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", rx_busy); end
        if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid: got %b expected 0", rx_valid); end
        n_rst = 1'b1;
        idle_bits(12);
        checks++;
        if (got_q.size() != 0) begin errors++; $display("[TB] FAIL midreset_pulses: got %0d expected 0", got_q.size()); end
        send_frame(8'h12, 1'b1, (^8'h12) ^ PARITY_ODD);
        send_frame(8'h34, 1'b1, (^8'h34) ^ PARITY_ODD);
        exp_q.push_back(model_frame(8'h12, 1'b1, (^8'h12) ^ PARITY_ODD));
        exp_q.push_back(model_frame(8'h34, 1'b1, (^8'h34) ^ PARITY_ODD));
        repeat (2) @(negedge clk);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i].data !== exp_q[i].data) begin errors++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, got_q[i].data, exp_q[i].data); end
            end
        end
    endtask

    task automatic test_parity;
        got_q.delete();
        exp_q.delete();
        send_frame(8'h81, 1'b1, 1'b0);
        idle_bits(1);
        send_frame(8'h81, 1'b1, 1'b1);
        exp_q.push_back(model_frame(8'h81, 1'b1, 1'b0));
        exp_q.push_back(model_frame(8'h81, 1'b1, 1'b1));
        repeat (2) @(negedge clk);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL parity_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks += 2;
                if (got_q[i].data !== exp_q[i].data) begin errors++; $display("[TB] FAIL parity_data[%0d]: got %h expected %h", i, got_q[i].data, exp_q[i].data); end
                if (got_q[i].perr !== exp_q[i].perr) begin errors++; $display("[TB] FAIL parity_err[%0d]: got %b expected %b", i, got_q[i].perr, exp_q[i].perr); end
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] d;
        logic       stop;
        logic       par;
        got_q.delete();
        exp_q.delete();
        for (int n = 0; n < 20; n++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            par  = 1'($urandom_range(0, 1));
            send_frame(d, stop, par);
            exp_q.push_back(model_frame(d, stop, par));
            idle_bits($urandom_range(1, 3));
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL random_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks += 3;
                if (got_q[i].data !== exp_q[i].data) begin errors++; $display("[TB] FAIL random_data[%0d]: got %h expected %h", i, got_q[i].data, exp_q[i].data); end
                if (got_q[i].ferr !== exp_q[i].ferr) begin errors++; $display("[TB] FAIL random_ferr[%0d]: got %b expected %b", i, got_q[i].ferr, exp_q[i].ferr); end
                if (got_q[i].perr !== exp_q[i].perr) begin errors++; $display("[TB] FAIL random_perr[%0d]: got %b expected %b", i, got_q[i].perr, exp_q[i].perr); end
            end
        end
    endtask

    initial begin
        $display("[TB] starting uart_rx_deserializer bench");
        test_reset();
        test_basic_frame();
        test_glitch();
        test_break();
        test_reset_midframe();
        test_parity();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
